audio_i2s_tx: RTL and testbench
===============================

# audio_i2s_tx

Serializes the filtered stereo 16-bit audio stream into a standard I2S frame (bit clock, word select, serial data) for an external DAC or HDMI audio bridge. It consumes the parallel samples and `sample_ce` strobe produced by the audio filter chain, so it sits downstream of the IIR filter and DC blocker. A one-deep holding register decouples the filter's sample rate from the I2S frame rate. Underrun and overrun are flagged, never stalled.

## Interface
Parameters:
- `SCLK_DIV`, 4: `clk` cycles per half bit-clock period, ≥1. Frame rate = clk / (SCLK_DIV·128). Example: 24.576 MHz with 4 gives 48 kHz.
- `STEREO`, 1: 0 = mono. `input_r` is ignored and the right slot carries `input_l`.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `sample_ce` in 1: one-cycle strobe. Captures `input_l`/`input_r`.
- `input_l`, `input_r` in 16 each: signed samples.
- `mute` in 1: forces every transmitted data bit to 0. Framing continues.
- `i2s_bclk` out 1: bit clock, registered.
- `i2s_lrclk` out 1: word select. 0 = left, 1 = right. Registered.
- `i2s_data` out 1: serial data, MSB first, registered.
- `underrun` out 1: one-cycle pulse when a frame reuses the previous sample.
- `overrun` out 1: one-cycle pulse when a pending sample is overwritten.

## Operation
- **Divider.** `div_cnt` counts 0..SCLK_DIV-1. When `div_cnt` = SCLK_DIV-1:
  - `div_cnt` ← 0 and `i2s_bclk` toggles.
  - If `i2s_bclk` was 1, the toggle is a *falling event*.
- **Slot counter.** 6-bit `p` advances by 1 (mod 64) on each falling event. All data and word-select updates occur only on falling events, so the DAC samples on rising `i2s_bclk`.
- **Word select.** On each falling event, `i2s_lrclk` ← (new p ≥ 32).
- **Data.** On each falling event, `i2s_data` takes the bit for new p:
  - p = 1..16: `L[16-p]`.
  - p = 33..48: `R[48-p]`.
  - All other p: 0.
  - `mute` = 1 forces 0.
  - This is the standard I2S one-bit delay after the LRCLK edge. Each slot is 32 bits: the 16-bit sample followed by 16 zero bits.
- **Frame latch** on the falling event where new p = 0:
  - If `hold_valid`: `{L,R}` ← hold and `hold_valid` ← 0.
  - Otherwise `{L,R}` is kept and `underrun` pulses.
- **Capture.** On `sample_ce`:
  - hold ← {`input_l`, STEREO ? `input_r` : `input_l`} and `hold_valid` ← 1.
  - If `hold_valid` was already 1 and no latch occurs this cycle, `overrun` pulses. The newer sample wins.
- **Simultaneous `sample_ce` and frame latch:** the incoming sample bypasses straight into `{L,R}`, `hold_valid` ← 0, and neither flag pulses. The older pending sample is silently dropped.
- **Reset values:**
  - `div_cnt` = 0, `i2s_bclk` = 0, p = 63, `i2s_lrclk` = 1, `i2s_data` = 0.
  - `{L,R}` = 0, hold = 0, `hold_valid` = 0, `underrun` = 0, `overrun` = 0.
  - Reset mid-frame aborts the frame immediately. There is no partial-frame completion.

## Timing
- First rising `i2s_bclk` is at cycle SCLK_DIV after reset deassertion. First falling event is at cycle 2·SCLK_DIV, giving p = 0, `i2s_lrclk` = 0 and the latch. This first latch reports `underrun` unless a sample arrived earlier.
- Falling events occur every 2·SCLK_DIV cycles. A frame is 64 falling events, i.e. 128·SCLK_DIV cycles.
- Latency from `sample_ce` to MSB on `i2s_data`: at most one frame plus 2·SCLK_DIV cycles. The MSB appears one falling event after the latch.
- All outputs change only on the `clk` edge of the falling event, except the flags. `underrun` is asserted in the latch cycle; `overrun` in the `sample_ce` cycle.
- `mute` is sampled at each falling event and takes effect on the next data bit.

## Test plan
- **Basic frame.** SCLK_DIV=2, reset, then `sample_ce` with L=16'hA5C3, R=16'h0F0F before the first latch.
  - Frame 1 carries A5C3 on p=1..16 and 0F0F on p=33..48. All other bits are 0.
  - `i2s_lrclk` falls at p=0 and rises at p=32.
  - Falling events fall every 4 cycles.
- **Underrun.** No `sample_ce` for 2 frames after the basic-frame sample.
  - `underrun` pulses once per latch.
  - Both frames repeat A5C3/0F0F.
- **Overrun.** Two `sample_ce` strobes (1111/2222, then 3333/4444) within one frame.
  - `overrun` pulses once, on the second strobe.
  - The next frame transmits 3333/4444.
- **Collision.** `sample_ce` (7FFF/8000) in exactly the latch cycle while hold holds 1234/5678.
  - The frame transmits 7FFF/8000.
  - No flag pulses and `hold_valid` = 0 afterwards.
- **Mono and mute.** STEREO=0, `input_l`=16'h8001, `input_r`=16'hFFFF: both slots carry 8001. Asserting `mute` mid-left-slot zeroes the data from the next falling event while `i2s_lrclk`/`i2s_bclk` continue.
- **Reset mid-frame.** Assert `reset` at p=20. Next cycle: all outputs are at their reset values, and the frame restarts with the first latch 2·SCLK_DIV cycles after deassertion.

Source files
------------

// File: rtl/audio_i2s_tx_if.sv
// Sample input bus and I2S output bundle for audio_i2s_tx.
// The master side feeds parallel samples and mute and observes the serial frame.
interface audio_i2s_tx_if;
    logic        sample_ce;
    logic [15:0] input_l;
    logic [15:0] input_r;
    logic        mute;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_data;
    logic        underrun;
    logic        overrun;

    modport master (
        output sample_ce, input_l, input_r, mute,
        input  i2s_bclk, i2s_lrclk, i2s_data, underrun, overrun
    );

    modport slave (
        input  sample_ce, input_l, input_r, mute,
        output i2s_bclk, i2s_lrclk, i2s_data, underrun, overrun
    );
endinterface

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: serializes stereo 16-bit samples into 64-bit-clock frames.
// A one-deep holding register decouples the sample strobe from the frame rate.
// Underrun and overrun are reported as single-cycle pulses and never stall.
module audio_i2s_tx #(
    parameter int SCLK_DIV = 4,
    parameter bit STEREO   = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    audio_i2s_tx_if.slave  bus
);

    localparam int               DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

    logic [DIV_W-1:0] r_divCnt;
    logic             r_bclk;
    logic             r_lrclk;
    logic             r_data;
    logic [5:0]       r_p;
    logic [15:0]      r_left;
    logic [15:0]      r_right;
    logic [15:0]      r_holdL;
    logic [15:0]      r_holdR;
    logic             r_holdValid;
    logic             r_underrun;
    logic             r_overrun;

    logic             w_tick;
    logic             w_fall;
    logic             w_latch;
    logic [5:0]       w_pNext;
    logic [3:0]       w_idx;
    logic [15:0]      w_inR;
    logic             w_bit;

    assign w_tick  = (r_divCnt == DIV_LAST);
    assign w_fall  = w_tick & r_bclk;
    assign w_pNext = r_p + 6'd1;
    assign w_latch = w_fall & (w_pNext == 6'd0);
    assign w_inR   = STEREO ? bus.input_r : bus.input_l;
    // 16-p and 48-p are both -p modulo 16, so one index serves both slots
    assign w_idx   = 4'd0 - w_pNext[3:0];

    // Select the data bit for the upcoming slot position, zero outside the sample bits
    always_comb begin
        w_bit = 1'b0;
        if (w_pNext >= 6'd1 && w_pNext <= 6'd16) begin
            w_bit = r_left[w_idx];
        end else if (w_pNext >= 6'd33 && w_pNext <= 6'd48) begin
            w_bit = r_right[w_idx];
        end
        if (bus.mute) begin
            w_bit = 1'b0;
        end
    end

    // Bit-clock divider and slot counter; word select and data only move on falling events
    always_ff @(posedge clk) begin
        if (reset) begin
            r_divCnt <= '0;
            r_bclk   <= 1'b0;
            r_p      <= 6'd63;
            r_lrclk  <= 1'b1;
            r_data   <= 1'b0;
        end else begin
            if (w_tick) begin
                r_divCnt <= '0;
                r_bclk   <= ~r_bclk;
            end else begin
                r_divCnt <= r_divCnt + DIV_W'(1);
            end
            if (w_fall) begin
                r_p     <= w_pNext;
                r_lrclk <= w_pNext[5];
                r_data  <= w_bit;
            end
        end
    end

    // Holding register, frame latch and status pulses; a strobe on the latch cycle bypasses hold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_left      <= '0;
            r_right     <= '0;
            r_holdL     <= '0;
            r_holdR     <= '0;
            r_holdValid <= 1'b0;
            r_underrun  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
            if (w_latch) begin
                if (bus.sample_ce) begin
                    r_left  <= bus.input_l;
                    r_right <= w_inR;
                end else if (r_holdValid) begin
                    r_left  <= r_holdL;
                    r_right <= r_holdR;
                end else begin
                    r_underrun <= 1'b1;
                end
                r_holdValid <= 1'b0;
            end else if (bus.sample_ce) begin
                r_holdL     <= bus.input_l;
                r_holdR     <= w_inR;
                r_holdValid <= 1'b1;
                r_overrun   <= r_holdValid;
            end
        end
    end

    assign bus.i2s_bclk  = r_bclk;
    assign bus.i2s_lrclk = r_lrclk;
    assign bus.i2s_data  = r_data;
    assign bus.underrun  = r_underrun;
    assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: a stereo and a mono instance share clock and reset.
// A monitor rebuilds each 64-slot frame from the falling bit-clock edges.
module tb_audio_i2s_tx;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        mute;
        logic [15:0] expL;
        logic [15:0] expR;
    } vec_t;

    localparam logic [63:0] LR_EXP = {32'hFFFF_FFFF, 32'h0000_0000};

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;

    audio_i2s_tx_if busS();
    audio_i2s_tx_if busM();

    audio_i2s_tx #(.SCLK_DIV(2), .STEREO(1'b1)) dutStereo (
        .clk   (clk),
        .reset (reset),
        .bus   (busS)
    );

    audio_i2s_tx #(.SCLK_DIV(2), .STEREO(1'b0)) dutMono (
        .clk   (clk),
        .reset (reset),
        .bus   (busM)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    logic        prevBclk = 1'b0;
    logic [5:0]  tbP      = 6'd63;
    int          cyc      = 0;
    int          lastFall = -1;
    int          gapErr   = 0;
    int          frameCnt = 0;
    int          urCnt    = 0;
    int          orCnt    = 0;
    logic [63:0] curD, curLr, curMD, curMLr;
    logic [63:0] doneD, doneLr, doneMD, doneMLr;

    // Frame monitor: detect falling bit-clock edges away from the active edge and log each slot
    always @(negedge clk) begin
        if (reset) begin
            prevBclk = 1'b0;
            tbP      = 6'd63;
            cyc      = 0;
            lastFall = -1;
        end else begin
            cyc = cyc + 1;
            if (prevBclk && !busS.i2s_bclk) begin
                tbP         = tbP + 6'd1;
                curD[tbP]   = busS.i2s_data;
                curLr[tbP]  = busS.i2s_lrclk;
                curMD[tbP]  = busM.i2s_data;
                curMLr[tbP] = busM.i2s_lrclk;
                if (lastFall >= 0 && (cyc - lastFall) != 4) gapErr = gapErr + 1;
                lastFall = cyc;
                if (tbP == 6'd63) begin
                    doneD    = curD;
                    doneLr   = curLr;
                    doneMD   = curMD;
                    doneMLr  = curMLr;
                    frameCnt = frameCnt + 1;
                end
            end
            prevBclk = busS.i2s_bclk;
            if (busS.underrun) urCnt = urCnt + 1;
            if (busS.overrun)  orCnt = orCnt + 1;
        end
    end

    // Hard stop in case a bounded wait itself misbehaves
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r);
        busS.sample_ce = 1'b1;
        busS.input_l   = l;
        busS.input_r   = r;
        tick();
        busS.sample_ce = 1'b0;
    endtask

    task automatic waitFrame();
        int start = frameCnt;
        int n = 0;
        while (frameCnt == start && n < 400) begin
            @(posedge clk);
            n++;
        end
        checkOutput("frameWait", 64'(frameCnt != start), 64'd1);
        #1;
    endtask

    task automatic waitSlot(input int frames, input logic [5:0] slot);
        int n = 0;
        while (!(tbP == slot && frameCnt == frames) && n < 400) begin
            @(posedge clk);
            n++;
        end
        checkOutput("slotWait", 64'(tbP == slot), 64'd1);
        #1;
    endtask

    function automatic logic [15:0] slotWord(input logic [63:0] v, input int base);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[15-i] = v[base+i];
        return w;
    endfunction

    function automatic logic [63:0] padBits(input logic [63:0] v);
        logic [63:0] p = v;
        for (int i = 1; i <= 16; i++) p[i] = 1'b0;
        for (int i = 33; i <= 48; i++) p[i] = 1'b0;
        return p;
    endfunction

    task automatic checkFrame(input string tag, input logic [15:0] expL, input logic [15:0] expR);
        checkOutput({tag, "_left"},  64'(slotWord(doneD, 1)),  64'(expL));
        checkOutput({tag, "_right"}, 64'(slotWord(doneD, 33)), 64'(expR));
        checkOutput({tag, "_pad"},   padBits(doneD), 64'd0);
        checkOutput({tag, "_lrclk"}, doneLr, LR_EXP);
    endtask

    vec_t vecs[5];

    initial begin
        int u0, o0, n;

        vecs[0] = '{l: 16'hFFFF, r: 16'h0000, mute: 1'b0, expL: 16'hFFFF, expR: 16'h0000};
        vecs[1] = '{l: 16'h0001, r: 16'h8000, mute: 1'b0, expL: 16'h0001, expR: 16'h8000};
        vecs[2] = '{l: 16'h5A5A, r: 16'hA5A5, mute: 1'b1, expL: 16'h0000, expR: 16'h0000};
        vecs[3] = '{l: 16'h8000, r: 16'h0001, mute: 1'b0, expL: 16'h8000, expR: 16'h0001};
        vecs[4] = '{l: 16'h1234, r: 16'hFEDC, mute: 1'b0, expL: 16'h1234, expR: 16'hFEDC};

        busS.sample_ce = 1'b0; busS.input_l = '0; busS.input_r = '0; busS.mute = 1'b0;
        busM.sample_ce = 1'b0; busM.input_l = '0; busM.input_r = '0; busM.mute = 1'b0;

        // Reset values
        reset = 1'b1;
        repeat (3) tick();
        checkOutput("rst_bclk",     64'(busS.i2s_bclk),  64'd0);
        checkOutput("rst_lrclk",    64'(busS.i2s_lrclk), 64'd1);
        checkOutput("rst_data",     64'(busS.i2s_data),  64'd0);
        checkOutput("rst_underrun", 64'(busS.underrun),  64'd0);
        checkOutput("rst_overrun",  64'(busS.overrun),   64'd0);

        // Basic frame with first-latch timing
        reset = 1'b0;
        tick();
        checkOutput("c1_bclk", 64'(busS.i2s_bclk), 64'd0);
        busS.sample_ce = 1'b1; busS.input_l = 16'hA5C3; busS.input_r = 16'h0F0F;
        busM.sample_ce = 1'b1; busM.input_l = 16'h8001; busM.input_r = 16'hFFFF;
        tick();
        busS.sample_ce = 1'b0;
        busM.sample_ce = 1'b0;
        checkOutput("c2_bclk_rise", 64'(busS.i2s_bclk),  64'd1);
        checkOutput("c2_lrclk",     64'(busS.i2s_lrclk), 64'd1);
        tick();
        checkOutput("c3_bclk", 64'(busS.i2s_bclk), 64'd1);
        tick();
        checkOutput("c4_bclk_fall", 64'(busS.i2s_bclk),  64'd0);
        checkOutput("c4_lrclk",     64'(busS.i2s_lrclk), 64'd0);
        checkOutput("c4_underrun",  64'(busS.underrun),  64'd0);
        checkOutput("c4_data",      64'(busS.i2s_data),  64'd0);
        waitFrame();
        checkFrame("basic", 16'hA5C3, 16'h0F0F);
        checkOutput("fall_spacing", 64'(gapErr), 64'd0);
        checkOutput("mono_left",  64'(slotWord(doneMD, 1)),  64'h8001);
        checkOutput("mono_right", 64'(slotWord(doneMD, 33)), 64'h8001);
        checkOutput("mono_pad",   padBits(doneMD), 64'd0);

        // Two underrun frames; mono mute asserted mid-left-slot
        u0 = urCnt;
        waitSlot(1, 6'd8);
        busM.mute = 1'b1;
        waitFrame();
        checkFrame("under1", 16'hA5C3, 16'h0F0F);
        checkOutput("mute_left",  64'(slotWord(doneMD, 1)),  64'h8000);
        checkOutput("mute_right", 64'(slotWord(doneMD, 33)), 64'h0000);
        checkOutput("mute_lrclk", doneMLr, LR_EXP);
        waitFrame();
        checkFrame("under2", 16'hA5C3, 16'h0F0F);
        checkOutput("underrun_count", 64'(urCnt - u0), 64'd2);

        // Table-driven frames, each strobed just before the next latch
        for (int i = 0; i < 5; i++) begin
            u0 = urCnt;
            o0 = orCnt;
            busS.mute = vecs[i].mute;
            applyStimulus(vecs[i].l, vecs[i].r);
            waitFrame();
            checkFrame($sformatf("vec%0d", i), vecs[i].expL, vecs[i].expR);
            checkOutput($sformatf("vec%0d_underrun", i), 64'(urCnt - u0), 64'd0);
            checkOutput($sformatf("vec%0d_overrun", i),  64'(orCnt - o0), 64'd0);
        end
        busS.mute = 1'b0;

        // Overrun: two strobes inside one frame, the newer wins
        o0 = orCnt;
        repeat (4) tick();
        applyStimulus(16'h1111, 16'h2222);
        checkOutput("ovr_first", 64'(busS.overrun), 64'd0);
        tick();
        tick();
        applyStimulus(16'h3333, 16'h4444);
        checkOutput("ovr_second", 64'(busS.overrun), 64'd1);
        tick();
        checkOutput("ovr_pulse_end", 64'(busS.overrun), 64'd0);
        u0 = urCnt;
        waitFrame();
        waitFrame();
        checkFrame("overrun", 16'h3333, 16'h4444);
        checkOutput("ovr_count",    64'(orCnt - o0), 64'd1);
        checkOutput("ovr_underrun", 64'(urCnt - u0), 64'd0);

        // Collision: strobe on the latch cycle while hold is pending
        applyStimulus(16'h1234, 16'h5678);
        tick();
        u0 = urCnt;
        o0 = orCnt;
        applyStimulus(16'h7FFF, 16'h8000);
        checkOutput("coll_underrun", 64'(busS.underrun),  64'd0);
        checkOutput("coll_overrun",  64'(busS.overrun),   64'd0);
        checkOutput("coll_lrclk",    64'(busS.i2s_lrclk), 64'd0);
        waitFrame();
        checkFrame("collision", 16'h7FFF, 16'h8000);
        checkOutput("coll_ur_count", 64'(urCnt - u0), 64'd0);
        checkOutput("coll_or_count", 64'(orCnt - o0), 64'd0);
        u0 = urCnt;
        waitFrame();
        checkFrame("after_coll", 16'h7FFF, 16'h8000);
        checkOutput("after_coll_underrun", 64'(urCnt - u0), 64'd1);

        // Reset at slot 20 aborts the frame and restarts framing
        n = frameCnt;
        waitSlot(n, 6'd20);
        checkOutput("p20_lrclk", 64'(busS.i2s_lrclk), 64'd0);
        reset = 1'b1;
        tick();
        checkOutput("mid_rst_bclk",     64'(busS.i2s_bclk),  64'd0);
        checkOutput("mid_rst_lrclk",    64'(busS.i2s_lrclk), 64'd1);
        checkOutput("mid_rst_data",     64'(busS.i2s_data),  64'd0);
        checkOutput("mid_rst_underrun", 64'(busS.underrun),  64'd0);
        checkOutput("mid_rst_overrun",  64'(busS.overrun),   64'd0);
        checkOutput("mid_rst_mono_lr",  64'(busM.i2s_lrclk), 64'd1);
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("rst_c3_lrclk", 64'(busS.i2s_lrclk), 64'd1);
        checkOutput("rst_c3_bclk",  64'(busS.i2s_bclk),  64'd1);
        tick();
        checkOutput("rst_c4_lrclk",    64'(busS.i2s_lrclk), 64'd0);
        checkOutput("rst_c4_underrun", 64'(busS.underrun),  64'd1);
        checkOutput("rst_c4_bclk",     64'(busS.i2s_bclk),  64'd0);
        waitFrame();
        checkFrame("post_reset", 16'h0000, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
